// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encoding, command codes and TAP next-state function
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam logic [1:0] CMD_DR   = 2'd0;
  localparam logic [1:0] CMD_IR   = 2'd1;
  localparam logic [1:0] CMD_RST  = 2'd2;
  localparam logic [1:0] CMD_RSVD = 2'd3;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_HDR, S_SHIFT, S_TAIL, S_RST, S_DONE
  } seq_state_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TEST_LOGIC_RESET: tap_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    tap_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   tap_next = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       tap_next = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         tap_next = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         tap_next = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         tap_next = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         tap_next = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        tap_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   tap_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       tap_next = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         tap_next = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         tap_next = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         tap_next = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         tap_next = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        tap_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          tap_next = TEST_LOGIC_RESET;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - TCK divider with rise/fall tick strobes; parks TCK low when disabled
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  // Strobes are valid in the cycle before tck actually toggles.
  assign tick      = en && (cnt == '0);
  assign rise_tick = tick && !tck;
  assign fall_tick = tick && tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RELOAD;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= RELOAD;
      tck <= 1'b0;
    end else if (tick) begin
      cnt <= RELOAD;
      tck <= ~tck;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG scan initiator: command sequencer, shift/capture and TAP mirror
module jtag_scan_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SCAN_W  = 64,
  parameter int LEN_W   = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [SCAN_W-1:0] cmd_tdi,
  output logic              rsp_valid,
  output logic [SCAN_W-1:0] rsp_tdo,
  output logic              busy,
  output logic [3:0]        tap_state,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(SCAN_W);

  seq_state_t        state;
  tap_state_t        tap_q;
  logic [LEN_W-1:0]  cnt, cnt_nxt, len_q, len_c, cap_shift;
  logic [SCAN_W-1:0] tdi_sr, cap;
  logic              ir_q, run, is_scan, rise_tick, fall_tick;

  assign len_c     = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign cnt_nxt   = cnt + 1'b1;
  assign cap_shift = MAX_LEN - len_q;
  assign is_scan   = (cmd_type == CMD_DR) || (cmd_type == CMD_IR);
  assign run       = state inside {S_INIT, S_HDR, S_SHIFT, S_TAIL, S_RST};
  assign tap_state = tap_q;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (run),
    .tck       (tck),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // cnt indexes the TCK cycle within the current phase; tms/tdi for the
  // next cycle are set up on the falling tick that ends the current one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      tap_q     <= TEST_LOGIC_RESET;
      cnt       <= '0;
      len_q     <= '0;
      ir_q      <= 1'b0;
      tdi_sr    <= '0;
      cap       <= '0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_tdo   <= '0;
      busy      <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      if (rise_tick) begin
        tap_q <= tap_next(tap_q, tms);
        if (state == S_SHIFT) cap <= {tdo, cap[SCAN_W-1:1]};
      end
      case (state)
        S_IDLE: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            len_q     <= len_c;
            ir_q      <= (cmd_type == CMD_IR);
            tdi_sr    <= cmd_tdi;
            cap       <= '0;
            cnt       <= '0;
            if (!is_scan) begin
              state <= S_RST;
              tms   <= 1'b1;
            end else if (len_c == '0) begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_tdo   <= '0;
            end else begin
              state <= S_HDR;
              tms   <= 1'b1;
            end
          end
        end
        S_INIT, S_RST: if (fall_tick) begin
          if (cnt == LEN_W'(5)) begin
            cnt <= '0;
            if (state == S_INIT) begin
              state <= S_IDLE;
            end else begin
              state     <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_tdo   <= '0;
            end
          end else begin
            cnt <= cnt_nxt;
            tms <= (cnt < LEN_W'(4));
          end
        end
        S_HDR: if (fall_tick) begin
          if (cnt == (ir_q ? LEN_W'(3) : LEN_W'(2))) begin
            cnt    <= '0;
            state  <= S_SHIFT;
            tms    <= (len_q == LEN_W'(1));
            tdi    <= tdi_sr[0];
            tdi_sr <= tdi_sr >> 1;
          end else begin
            cnt <= cnt_nxt;
            tms <= ir_q && (cnt == '0);
          end
        end
        S_SHIFT: if (fall_tick) begin
          if (cnt == len_q - 1'b1) begin
            cnt   <= '0;
            state <= S_TAIL;
            tms   <= 1'b1;
            tdi   <= 1'b0;
          end else begin
            cnt    <= cnt_nxt;
            tms    <= (cnt_nxt == len_q - 1'b1);
            tdi    <= tdi_sr[0];
            tdi_sr <= tdi_sr >> 1;
          end
        end
        S_TAIL: if (fall_tick) begin
          if (cnt == LEN_W'(1)) begin
            cnt       <= '0;
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_tdo   <= cap >> cap_shift;
          end else begin
            cnt <= cnt_nxt;
            tms <= 1'b0;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb/tb_jtag_scan_master.sv - directed self-checking bench for jtag_scan_master
module tb_jtag_scan_master;
  import jtag_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        f_cmd_valid = 1'b0;
  logic [1:0]  cmd_type = 2'd0;
  logic [6:0]  cmd_len = 7'd0;
  logic [63:0] cmd_tdi = 64'd0;
  logic        tdo_one = 1'b0;

  logic        cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [63:0] rsp_tdo;
  logic [3:0]  tap_state;
  logic        f_cmd_ready, f_rsp_valid, f_busy, f_tck, f_tms, f_tdi;
  logic [63:0] f_rsp_tdo;
  logic [3:0]  f_tap_state;

  int checks = 0;
  int errors = 0;
  int rises = 0, f_rises = 0, rsp_pulses = 0, accepts = 0, ir_shift_cycles = 0;
  longint last_rise = 0, prev_rise = 0, f_last_rise = 0, f_prev_rise = 0, fall_t = 0;
  logic [255:0] tms_log, tdi_log;

  always #5 clk = ~clk;
  assign tdo = tdo_one ? 1'b1 : tdi;

  jtag_scan_master #(.CLK_DIV(4), .SCAN_W(64), .LEN_W(7)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_tdi(cmd_tdi),
    .rsp_valid(rsp_valid), .rsp_tdo(rsp_tdo), .busy(busy), .tap_state(tap_state),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  jtag_scan_master #(.CLK_DIV(1), .SCAN_W(64), .LEN_W(7)) dut_div1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_tdi(cmd_tdi),
    .rsp_valid(f_rsp_valid), .rsp_tdo(f_rsp_tdo), .busy(f_busy), .tap_state(f_tap_state),
    .tck(f_tck), .tms(f_tms), .tdi(f_tdi), .tdo(f_tdi)
  );

  always @(posedge tck) begin
    if (rises < 256) begin
      tms_log[rises] = tms;
      tdi_log[rises] = tdi;
    end
    prev_rise = last_rise;
    last_rise = $time;
    rises++;
  end

  always @(negedge tck) fall_t = $time;

  always @(posedge f_tck) begin
    f_prev_rise = f_last_rise;
    f_last_rise = $time;
    f_rises++;
  end

  always @(negedge clk) begin
    if (rsp_valid) rsp_pulses++;
    if (tap_state == SHIFT_IR) ir_shift_cycles++;
  end

  always @(posedge clk) if (cmd_valid && cmd_ready) accepts++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!cmd_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("ready_seen", cmd_ready, 1);
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rsp_seen", rsp_valid, 1);
    @(negedge clk);
    check("rsp_one_cycle", rsp_valid, 0);
  endtask

  task automatic send(input logic [1:0] t, input logic [6:0] l, input logic [63:0] d);
    wait_ready(2000);
    cmd_type  = t;
    cmd_len   = l;
    cmd_tdi   = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int b, p, a, s, n;
    logic [63:0] exp;

    repeat (3) @(negedge clk);
    check("rst_tck", tck, 0);
    check("rst_tms", tms, 1);
    check("rst_tdi", tdi, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_tdo", rsp_tdo, 0);
    check("rst_busy", busy, 1);
    check("rst_tap", tap_state, TEST_LOGIC_RESET);

    // Init sequence after reset release
    b = rises;
    reset_n = 1'b1;
    wait_ready(500);
    check("init_ready_delay", $time - fall_t, 15);
    check("init_tck", rises - b, 6);
    check("init_tms", tms_log[b +: 6], 6'b011111);
    check("init_tap", tap_state, RUN_TEST_IDLE);
    check("init_period", last_rise - prev_rise, 80);
    check("idle_busy", busy, 0);

    // 38-bit DR scan, tdo looped back from tdi
    b = rises; p = rsp_pulses;
    send(2'd0, 7'd38, 64'h0000_002A_5A5A_5A5A);
    wait_rsp(1000);
    check("dr38_tck", rises - b, 43);
    check("dr38_tdo", rsp_tdo, 64'h0000_002A_5A5A_5A5A);
    exp = 64'd0; exp[0] = 1'b1; exp[40] = 1'b1; exp[41] = 1'b1;
    check("dr38_tms", 64'(tms_log[b +: 43]), exp);
    check("dr38_tdi", 64'(tdi_log[b + 3 +: 38]), 64'h0000_002A_5A5A_5A5A);
    check("dr38_pulses", rsp_pulses - p, 1);
    check("dr38_tap", tap_state, RUN_TEST_IDLE);

    // 2-bit IR scan, tdo tied high
    tdo_one = 1'b1; b = rises; s = ir_shift_cycles;
    send(2'd1, 7'd2, 64'h2);
    wait_rsp(500);
    tdo_one = 1'b0;
    check("ir_tck", rises - b, 8);
    check("ir_tms", 64'(tms_log[b +: 8]), 64'h63);
    check("ir_tdi", 64'(tdi_log[b + 4 +: 2]), 64'h2);
    check("ir_tdo", rsp_tdo, 64'h3);
    check("ir_shift_seen", (ir_shift_cycles - s) > 0, 1);

    // Zero-length scan completes without TCK
    b = rises;
    send(2'd0, 7'd0, 64'hFFFF);
    check("len0_latency", rsp_valid, 1);
    wait_rsp(10);
    check("len0_tck", rises - b, 0);
    check("len0_tdo", rsp_tdo, 0);

    // Over-length scan is clamped to 64 bits
    b = rises;
    send(2'd0, 7'd100, 64'hDEAD_BEEF_0123_4567);
    wait_rsp(2000);
    check("len100_tck", rises - b, 69);
    check("len100_tdo", rsp_tdo, 64'hDEAD_BEEF_0123_4567);

    // Reserved type behaves as TAP reset
    b = rises;
    send(2'd3, 7'd5, 64'h0);
    wait_rsp(500);
    check("rsvd_tck", rises - b, 6);
    check("rsvd_tms", tms_log[b +: 6], 6'b011111);
    check("rsvd_tap", tap_state, RUN_TEST_IDLE);

    // cmd_valid held high across a whole scan
    wait_ready(100);
    a = accepts;
    cmd_type = 2'd0; cmd_len = 7'd4; cmd_tdi = 64'hA; cmd_valid = 1'b1;
    n = 0;
    while (!rsp_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("hold_first_rsp", rsp_valid, 1);
    check("hold_one_accept", accepts - a, 1);
    @(negedge clk);
    check("hold_ready_back", cmd_ready, 1);
    check("hold_not_yet", accepts - a, 1);
    @(negedge clk);
    check("hold_second_accept", accepts - a, 2);
    cmd_valid = 1'b0;
    wait_rsp(500);
    check("hold_tdo", rsp_tdo, 64'hA);

    // CLK_DIV=1 instance
    b = f_rises;
    check("div1_ready", f_cmd_ready, 1);
    cmd_type = 2'd0; cmd_len = 7'd38; cmd_tdi = 64'h0000_002A_5A5A_5A5A; f_cmd_valid = 1'b1;
    @(negedge clk);
    f_cmd_valid = 1'b0;
    n = 0;
    while (!f_rsp_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("div1_rsp_seen", f_rsp_valid, 1);
    check("div1_tck", f_rises - b, 43);
    check("div1_tdo", f_rsp_tdo, 64'h0000_002A_5A5A_5A5A);
    check("div1_period", f_last_rise - f_prev_rise, 20);

    // Reset pulsed in the middle of a DR shift
    wait_ready(100);
    b = rises; p = rsp_pulses;
    send(2'd0, 7'd38, 64'h0000_002A_5A5A_5A5A);
    n = 0;
    while ((rises - b) < 13 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached", (rises - b) >= 13, 1);
    reset_n = 1'b0;
    #1;
    check("abort_tck", tck, 0);
    check("abort_tms", tms, 1);
    check("abort_ready", cmd_ready, 0);
    check("abort_busy", busy, 1);
    check("abort_tap", tap_state, TEST_LOGIC_RESET);
    @(negedge clk);
    b = rises;
    reset_n = 1'b1;
    wait_ready(500);
    check("abort_no_rsp", rsp_pulses - p, 0);
    check("abort_init_tck", rises - b, 6);
    check("abort_init_tms", tms_log[b +: 6], 6'b011111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
